// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and
// occupancy states used by the ALU result output stage.
package alu_pkg;

   localparam int OP_W  = 3;
   localparam int FLG_W = 4;

   localparam logic [OP_W-1:0] OP_AND = 3'b000;
   localparam logic [OP_W-1:0] OP_OR  = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_XOR = 3'b011;
   localparam logic [OP_W-1:0] OP_SUB = 3'b100;
   localparam logic [OP_W-1:0] OP_RSH = 3'b101;
   localparam logic [OP_W-1:0] OP_LSH = 3'b110;
   localparam logic [OP_W-1:0] OP_NOR = 3'b111;

   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

   // Only add/sub carry a meaningful adder carry-out.
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generation for a selected ALU result.
// Flag vector layout is {overflow, carry, negative, zero}.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] result,
   input  logic [OP_W-1:0]  alu_in,
   input  logic             a_msb,
   input  logic             b_msb,
   input  logic             carry_in,
   output logic [FLG_W-1:0] flags
);

   logic is_add;
   logic is_sub;
   logic r_msb;
   logic ovf;

   assign is_add = (alu_in == OP_ADD);
   assign is_sub = (alu_in == OP_SUB);
   assign r_msb  = result[WIDTH-1];

   // b_msb is the pre-inversion sign, so sub overflows on unlike signs.
   always_comb begin
      ovf = 1'b0;
      unique case (1'b1)
         is_add:  ovf = (a_msb == b_msb) & (r_msb != a_msb);
         is_sub:  ovf = (a_msb != b_msb) & (r_msb != a_msb);
         default: ovf = 1'b0;
      endcase
   end

   always_comb begin
      flags        = '0;
      flags[FLG_Z] = (result == '0);
      flags[FLG_N] = r_msb;
      flags[FLG_C] = is_arith(alu_in) & carry_in;
      flags[FLG_V] = ovf;
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag generation plus a small result FIFO.
// Optional sticky overflow flag is enabled by ALU_STICKY_OVF_EN.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] result,
   input  logic [OP_W-1:0]  alu_in,
   input  logic             a_msb,
   input  logic             b_msb,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [OP_W-1:0]  out_op,
`ifdef ALU_STICKY_OVF_EN
   output logic             sticky_ovf,
   input  logic             ovf_clear,
`endif
   output logic [FLG_W-1:0] out_flags
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] mem_res [DEPTH];
   logic [OP_W-1:0]  mem_op  [DEPTH];
   logic [FLG_W-1:0] mem_flg [DEPTH];

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   occ_e             state_q;
   occ_e             state_d;

   logic [WIDTH-1:0] last_res;
   logic [OP_W-1:0]  last_op;
   logic [FLG_W-1:0] last_flg;

   logic [FLG_W-1:0] new_flg;
   logic             push;
   logic             pop;

   alu_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .result   (result),
      .alu_in   (alu_in),
      .a_msb    (a_msb),
      .b_msb    (b_msb),
      .carry_in (carry_in),
      .flags    (new_flg)
   );

   // Handshake readiness comes only from the registered occupancy state.
   assign in_ready  = (state_q != OCC_FULL);
   assign out_valid = (state_q != OCC_EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = OCC_PARTIAL;
      if (count_d == '0) begin
         state_d = OCC_EMPTY;
      end else if (count_d == CNT_FULL) begin
         state_d = OCC_FULL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= OCC_EMPTY;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_res[wr_ptr] <= result;
         mem_op[wr_ptr]  <= alu_in;
         mem_flg[wr_ptr] <= new_flg;
      end
   end

   // Keeps the last presented entry visible once the FIFO runs empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_res <= '0;
         last_op  <= '0;
         last_flg <= '0;
      end else if (pop) begin
         last_res <= mem_res[rd_ptr];
         last_op  <= mem_op[rd_ptr];
         last_flg <= mem_flg[rd_ptr];
      end
   end

   always_comb begin
      out_result = last_res;
      out_op     = last_op;
      out_flags  = last_flg;
      if (out_valid) begin
         out_result = mem_res[rd_ptr];
         out_op     = mem_op[rd_ptr];
         out_flags  = mem_flg[rd_ptr];
      end
   end

`ifdef ALU_STICKY_OVF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky_ovf <= 1'b0;
      end else if (push & new_flg[FLG_V]) begin
         sticky_ovf <= 1'b1;
      end else if (ovf_clear) begin
         sticky_ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (DEPTH=2).
// Sticky overflow checks run only when ALU_STICKY_OVF_EN is defined.
module tb_alu_result_stage;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic [2:0]  alu_in;
   logic        a_msb;
   logic        b_msb;
   logic        carry_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_op;
   logic [3:0]  out_flags;
`ifdef ALU_STICKY_OVF_EN
   logic        sticky_ovf;
   logic        ovf_clear;
`endif

   int checks;
   int failures;

   alu_result_stage #(
      .DEPTH (2),
      .WIDTH (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .result     (result),
      .alu_in     (alu_in),
      .a_msb      (a_msb),
      .b_msb      (b_msb),
      .carry_in   (carry_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_op     (out_op),
`ifdef ALU_STICKY_OVF_EN
      .sticky_ovf (sticky_ovf),
      .ovf_clear  (ovf_clear),
`endif
      .out_flags  (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r,
                        input logic [2:0] op, input logic a,
                        input logic b, input logic c);
      in_valid = v;
      result   = r;
      alu_in   = op;
      a_msb    = a;
      b_msb    = b;
      carry_in = c;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      out_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
      ovf_clear = 1'b0;
`endif
      drive(1'b0, 32'h0, OP_AND, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_result", out_result, 32'h0);
      check("rst_out_op", {29'b0, out_op}, 32'd0);
      check("rst_out_flags", {28'b0, out_flags}, 32'd0);

      // add overflow into negative
      drive(1'b1, 32'h8000_0000, OP_ADD, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, OP_AND, 1'b0, 1'b0, 1'b0);
      check("add_valid", {31'b0, out_valid}, 32'd1);
      check("add_flags", {28'b0, out_flags}, 32'h0000_000a);
      check("add_result", out_result, 32'h8000_0000);
      check("add_op", {29'b0, out_op}, 32'd2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pop_empty_valid", {31'b0, out_valid}, 32'd0);
      check("empty_hold_result", out_result, 32'h8000_0000);
      check("empty_hold_flags", {28'b0, out_flags}, 32'h0000_000a);

      // sub to zero with carry, then and-zero pushed while popping
      drive(1'b1, 32'h0, OP_SUB, 1'b1, 1'b1, 1'b1);
      tick();
      check("sub_flags", {28'b0, out_flags}, 32'h0000_0005);
      drive(1'b1, 32'h0, OP_AND, 1'b1, 1'b1, 1'b1);
      out_ready = 1'b1;
      tick();
      check("and_flags", {28'b0, out_flags}, 32'h0000_0001);
      check("and_op", {29'b0, out_op}, 32'd0);
      drive(1'b1, 32'h7fff_ffff, OP_SUB, 1'b1, 1'b0, 1'b0);
      tick();
      check("sub_ovf_flags", {28'b0, out_flags}, 32'h0000_0008);
      drive(1'b1, 32'hffff_ffff, OP_XOR, 1'b1, 1'b1, 1'b1);
      tick();
      check("xor_flags", {28'b0, out_flags}, 32'h0000_0002);
      drive(1'b0, 32'h0, OP_AND, 1'b0, 1'b0, 1'b0);
      tick();
      out_ready = 1'b0;
      check("drain1_valid", {31'b0, out_valid}, 32'd0);

      // fill to full with the consumer stalled
      drive(1'b1, 32'h11, OP_OR, 1'b0, 1'b0, 1'b0);
      tick();
      check("fill1_in_ready", {31'b0, in_ready}, 32'd1);
      drive(1'b1, 32'h22, OP_OR, 1'b0, 1'b0, 1'b0);
      tick();
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("full_head", out_result, 32'h11);
      drive(1'b1, 32'h33, OP_OR, 1'b0, 1'b0, 1'b0);
      tick();
      check("full_hold_head", out_result, 32'h11);
      check("full_still", {31'b0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, OP_AND, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
      check("drain_second", out_result, 32'h22);
      check("drain_in_ready", {31'b0, in_ready}, 32'd1);
      check("drain_valid", {31'b0, out_valid}, 32'd1);
      tick();
      check("drain_empty", {31'b0, out_valid}, 32'd0);
      check("drain_hold", out_result, 32'h22);

      // streaming push+pop, occupancy stays at one
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 32'(i), OP_OR, 1'b0, 1'b0, 1'b0);
         tick();
         check($sformatf("stream_res%0d", i), out_result, 32'(i));
         check($sformatf("stream_rdy%0d", i), {31'b0, in_ready}, 32'd1);
      end
      drive(1'b0, 32'h0, OP_AND, 1'b0, 1'b0, 1'b0);
      tick();
      check("stream_end_valid", {31'b0, out_valid}, 32'd0);
      check("stream_end_hold", out_result, 32'd10);

      // reset with two entries held
      out_ready = 1'b0;
      drive(1'b1, 32'h8000_0000, OP_ADD, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      drive(1'b0, 32'h0, OP_AND, 1'b0, 1'b0, 1'b0);
      check("pre_rst_full", {31'b0, in_ready}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
      check("mid_rst_result", out_result, 32'h0);
      check("mid_rst_flags", {28'b0, out_flags}, 32'd0);
      tick();
      check("post_rst_valid", {31'b0, out_valid}, 32'd0);

`ifdef ALU_STICKY_OVF_EN
      check("sticky_rst", {31'b0, sticky_ovf}, 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 32'h8000_0000, OP_ADD, 1'b0, 1'b0, 1'b0);
      tick();
      check("sticky_set", {31'b0, sticky_ovf}, 32'd1);
      drive(1'b1, 32'h5, OP_AND, 1'b0, 1'b0, 1'b0);
      tick();
      check("sticky_hold1", {31'b0, sticky_ovf}, 32'd1);
      drive(1'b1, 32'h6, OP_OR, 1'b1, 1'b0, 1'b0);
      tick();
      check("sticky_hold2", {31'b0, sticky_ovf}, 32'd1);
      drive(1'b1, 32'h7, OP_XOR, 1'b1, 1'b1, 1'b0);
      tick();
      check("sticky_hold3", {31'b0, sticky_ovf}, 32'd1);
      drive(1'b1, 32'h7fff_ffff, OP_SUB, 1'b1, 1'b0, 1'b0);
      ovf_clear = 1'b1;
      tick();
      check("sticky_set_wins", {31'b0, sticky_ovf}, 32'd1);
      drive(1'b0, 32'h0, OP_AND, 1'b0, 1'b0, 1'b0);
      tick();
      ovf_clear = 1'b0;
      check("sticky_cleared", {31'b0, sticky_ovf}, 32'd0);
      out_ready = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
